sm_hex_display: RTL

Multiplexed 8-digit seven-segment scanner that sits directly downstream of the CPU top level. It consumes the 32-bit register value (`regData`) and shows it as 8 hex digits on a common-anode board display. The value is snapshotted once per full scan frame, so a digit never mixes old and new data. Scan rate, inter-digit ghost blanking and leading-zero suppression are built in.

---
 rtl/sm_hex_display.sv | 105 ++++++++++
 1 files changed

// File: rtl/sm_hex_display.sv
// Eight-digit multiplexed hex scanner for a common-anode seven-segment display.
// The displayed word is snapshotted once per frame so a scan never mixes old and new data.
module sm_hex_display #(
  parameter int unsigned SCAN_DIV = 1024,
  parameter int unsigned GUARD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        blankZeros,
  input  logic        freeze,
  output logic [7:0]  anodes,
  output logic [7:0]  segments,
  output logic        frameDone
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] GuardC = CntW'(GUARD);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      digit_q, digit_d;
  logic [31:0]     shown_q, shown_d;
  logic [7:0]      anodes_q, anodes_d;
  logic [7:0]      segments_q, segments_d;
  logic            frame_done_q, frame_done_d;

  logic            tick;
  logic            frame_end;
  logic            upper_zero;
  logic            blank;
  logic [3:0]      nibble;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // True when the current digit and every more-significant nibble are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((3'(i) >= digit_q) && (shown_q[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  always_comb begin
    tick      = (cnt_q == CntMax);
    frame_end = tick && (digit_q == 3'd7);
    nibble    = shown_q[{digit_q, 2'b00} +: 4];

    cnt_d   = tick ? '0 : cnt_q + CntW'(1);
    digit_d = tick ? digit_q + 3'd1 : digit_q;
    shown_d = (frame_end && !freeze) ? value : shown_q;

    blank = (cnt_q < GuardC) || (blankZeros && (digit_q != 3'd0) && upper_zero);

    anodes_d     = blank ? 8'hFF : ~(8'h01 << digit_q);
    segments_d   = blank ? 8'hFF : {1'b1, hex7(nibble)};
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      digit_q      <= 3'd0;
      shown_q      <= 32'd0;
      anodes_q     <= 8'hFF;
      segments_q   <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      shown_q      <= shown_d;
      anodes_q     <= anodes_d;
      segments_q   <= segments_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anodes    = anodes_q;
  assign segments  = segments_q;
  assign frameDone = frame_done_q;

endmodule
